mario_anim_ctrl: RTL and testbench
==================================

Name: mario_anim_ctrl

Overview:
- Sequencer that drives the 4-bit animate_state select of the Mario sprite color block.
- Takes movement/status flags from the game logic and a once-per-frame tick from the VGA timing.
- Steps through the walk, climb and die frame cycles at parameterised frame rates.
- Signals game logic with a one-cycle pulse when the death animation finishes.

Parameters:
- FRAMES_PER_STEP, 6, frame ticks per walk-cycle image.
- FRAMES_PER_CLIMB, 8, frame ticks per ladder image.
- FRAMES_PER_DIE, 8, frame ticks per death image.
- DIE_LOOPS, 2, full DIE1..DIE4 passes before the final hold; legal range 1..15.
- CNT_W, 4, width of the frame counter; must hold max(FRAMES_PER_*) - 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- frame_tick  in  1  one-clk pulse per video frame.
- pause  in  1  high: freeze all state, counters and outputs.
- move_dir  in  2  00 none, 01 left, 10 right, 11 treated as none.
- airborne  in  1  Mario is jumping or falling.
- on_ladder  in  1  Mario is attached to a ladder.
- climb_move  in  1  Mario is moving on the ladder; ignored unless on_ladder.
- dead  in  1  death event, level.
- animate_state  out  4  sprite image select; codes come from the shared package.
- die_done  out  1  one-clk pulse when the death animation completes.

Behaviour:
- Reset when rst_n is low at a clk edge:
  - FSM to IDLE; animate_state = STAND (0000); die_done = 0.
  - facing = right; frame_cnt = 0; phase = 0; loop_cnt = 0.
- All outputs are registered. An input change appears on animate_state one clk later.
- pause high: no register changes, except synchronous reset still applies.
- FSM states: IDLE, WALK, AIR, CLIMB, DYING, DEAD.
- Target state, evaluated every clk when not in DYING/DEAD, in priority order:
  - dead → DYING
  - airborne → AIR
  - on_ladder → CLIMB
  - move_dir 01/10 → WALK
  - otherwise → IDLE
- Any state change, or a direction reversal inside WALK, clears frame_cnt and phase and loads that state's first image in the same clk.
- Frame advance: when frame_tick is high and frame_cnt == N-1, set frame_cnt = 0 and phase + 1. Otherwise, on frame_tick, frame_cnt + 1. No advance on clks without frame_tick.
- IDLE: animate_state = STAND.
- WALK:
  - facing follows move_dir.
  - Left cycle: WALK_LEFT1 → WALK_LEFT2 → WALK_MID → repeat.
  - Right cycle: WALK_RIGHT1 → WALK_RIGHT2 → WALK_MID → repeat.
  - Phase wraps 2 → 0. N = FRAMES_PER_STEP.
- AIR:
  - FLY_LEFT if facing left, else FLY_RIGHT.
  - move_dir updates facing while in AIR, and the output follows next clk.
- CLIMB:
  - Alternates CLAMP1/CLAMP2 only while climb_move = 1, N = FRAMES_PER_CLIMB.
  - climb_move = 0 holds the current image and frame_cnt.
- DYING:
  - Entered from any state, including mid-walk or mid-air.
  - Sequence DIE1 → DIE2 → DIE3 → DIE4, N = FRAMES_PER_DIE.
  - After DIE4 completes, loop_cnt + 1. If loop_cnt < DIE_LOOPS, restart at DIE1.
  - Otherwise go to DEAD, with die_done = 1 for exactly that one clk.
  - Other inputs and the dead level are ignored until DEAD.
- DEAD:
  - Hold DIE4.
  - When dead = 0, go to IDLE and load STAND, facing = right, loop_cnt = 0.
- Simultaneous dead and airborne: dead wins.
- frame_tick coinciding with a state change: the change wins and frame_cnt = 0.

Decomposition:
- Shared package mario_pkg:
  - 4-bit animation codes: STAND 0000, WALK_LEFT1 0001, WALK_LEFT2 0010, WALK_MID 0011, WALK_RIGHT1 0100, WALK_RIGHT2 0101, FLY_LEFT 0110, FLY_RIGHT 0111, CLAMP1 1000, CLAMP2 1001, DIE1 1010, DIE2 1011, DIE3 1100, DIE4 1101.
  - FSM state enum.
  - move_dir encodings.
- One sub-module: anim_frame_timer. It holds the frame_cnt/phase counter with inputs clear, enable, frame_tick and limit N, and outputs phase and wrap.

Test Plan:
- Reset with rst_n = 0 for 2 clks, then idle inputs → animate_state = 0000, die_done = 0.
- move_dir = 10 held for 18 ticks with FRAMES_PER_STEP = 6 → output 0100 for ticks 0-5, 0101 for ticks 6-11, 0011 for ticks 12-17, then 0100. At tick 8, switch move_dir to 01 → next clk output 0001 and frame_cnt restarts.
- Walk right, then airborne = 1 → 0111. While airborne, move_dir = 01 → 0110. Drop airborne with move_dir = 00 → 0000.
- on_ladder = 1, climb_move = 1 for 16 ticks → 1000 for 8 ticks, then 1001. Set climb_move = 0 → hold 1001 for 20 ticks.
- dead pulse mid-walk with FRAMES_PER_DIE = 8, DIE_LOOPS = 2 → 1010..1101 repeated twice over 64 ticks. die_done is high exactly 1 clk. Output holds 1101 until dead = 0, then 0000.
- pause = 1 for 10 ticks mid-walk → animate_state and counters unchanged. Assert rst_n = 0 during DYING → next clk 0000, FSM in IDLE.

Source files
------------

// File: rtl/mario_pkg.sv
// Shared definitions for the Mario sprite animation path: image codes,
// sequencer states, move_dir encodings and the image-select decode.
package mario_pkg;

  localparam logic [3:0] ANIM_STAND       = 4'b0000;
  localparam logic [3:0] ANIM_WALK_LEFT1  = 4'b0001;
  localparam logic [3:0] ANIM_WALK_LEFT2  = 4'b0010;
  localparam logic [3:0] ANIM_WALK_MID    = 4'b0011;
  localparam logic [3:0] ANIM_WALK_RIGHT1 = 4'b0100;
  localparam logic [3:0] ANIM_WALK_RIGHT2 = 4'b0101;
  localparam logic [3:0] ANIM_FLY_LEFT    = 4'b0110;
  localparam logic [3:0] ANIM_FLY_RIGHT   = 4'b0111;
  localparam logic [3:0] ANIM_CLAMP1      = 4'b1000;
  localparam logic [3:0] ANIM_CLAMP2      = 4'b1001;
  localparam logic [3:0] ANIM_DIE1        = 4'b1010;
  localparam logic [3:0] ANIM_DIE2        = 4'b1011;
  localparam logic [3:0] ANIM_DIE3        = 4'b1100;
  localparam logic [3:0] ANIM_DIE4        = 4'b1101;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  localparam logic FACE_LEFT  = 1'b0;
  localparam logic FACE_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK,
    S_AIR,
    S_CLIMB,
    S_DYING,
    S_DEAD
  } anim_state_t;

  // Image select for a given state, facing and cycle phase.
  function automatic logic [3:0] anim_image(input anim_state_t st,
                                            input logic facing,
                                            input logic [1:0] phase);
    logic [3:0] img;
    img = ANIM_STAND;
    case (st)
      S_IDLE:  img = ANIM_STAND;
      S_WALK: begin
        case (phase)
          2'd0:    img = (facing == FACE_LEFT) ? ANIM_WALK_LEFT1 : ANIM_WALK_RIGHT1;
          2'd1:    img = (facing == FACE_LEFT) ? ANIM_WALK_LEFT2 : ANIM_WALK_RIGHT2;
          default: img = ANIM_WALK_MID;
        endcase
      end
      S_AIR:   img = (facing == FACE_LEFT) ? ANIM_FLY_LEFT : ANIM_FLY_RIGHT;
      S_CLIMB: img = phase[0] ? ANIM_CLAMP2 : ANIM_CLAMP1;
      S_DYING: img = ANIM_DIE1 + {2'b00, phase};
      S_DEAD:  img = ANIM_DIE4;
      default: img = ANIM_STAND;
    endcase
    return img;
  endfunction

endpackage

// File: rtl/mario_anim_ctrl_frame_timer.sv
// Frame-tick divider: counts ticks up to a per-state limit and steps a
// 2-bit image phase that wraps after i_phase_last.
module anim_frame_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_frame_tick,
  input  logic [CNT_W:0]   i_limit,
  input  logic [1:0]       i_phase_last,
  output logic [1:0]       o_phase,
  output logic [1:0]       o_phase_nxt,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_phase;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_phase_nxt;
  logic [CNT_W:0]   w_cnt_last;
  logic             w_step;
  logic             w_wrap;

  always_comb begin
    w_cnt_last  = i_limit - 1'b1;
    w_step      = i_enable & i_frame_tick;
    w_wrap      = w_step & ({1'b0, r_cnt} == w_cnt_last);
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    // Clear beats a coincident tick so a new state always starts at count 0.
    if (i_clear) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = 2'd0;
    end else if (w_wrap) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = (r_phase == i_phase_last) ? 2'd0 : r_phase + 2'd1;
    end else if (w_step) begin
      w_cnt_nxt   = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 2'd0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign o_phase     = r_phase;
  assign o_phase_nxt = w_phase_nxt;
  assign o_wrap      = w_wrap & ~i_clear;

endmodule

// File: rtl/mario_anim_ctrl.sv
// Mario sprite animation sequencer: turns movement/status flags and the
// per-frame tick into the registered animate_state image select.
module mario_anim_ctrl
  import mario_pkg::*;
#(
  parameter int FRAMES_PER_STEP  = 6,
  parameter int FRAMES_PER_CLIMB = 8,
  parameter int FRAMES_PER_DIE   = 8,
  parameter int DIE_LOOPS        = 2,
  parameter int CNT_W            = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [1:0] move_dir,
  input  logic       airborne,
  input  logic       on_ladder,
  input  logic       climb_move,
  input  logic       dead,
  output logic [3:0] animate_state,
  output logic       die_done
);

  localparam logic [CNT_W:0] LIM_STEP  = (CNT_W+1)'(FRAMES_PER_STEP);
  localparam logic [CNT_W:0] LIM_CLIMB = (CNT_W+1)'(FRAMES_PER_CLIMB);
  localparam logic [CNT_W:0] LIM_DIE   = (CNT_W+1)'(FRAMES_PER_DIE);
  localparam logic [3:0]     LOOPS     = 4'(DIE_LOOPS);

  anim_state_t    r_state;
  logic           r_facing;
  logic [3:0]     r_loop_cnt;

  anim_state_t    w_target;
  anim_state_t    w_state_nxt;
  logic           w_dir_valid;
  logic           w_facing_nxt;
  logic           w_clear;
  logic           w_enable;
  logic [CNT_W:0] w_limit;
  logic [1:0]     w_phase_last;
  logic [1:0]     w_phase;
  logic [1:0]     w_phase_nxt;
  logic           w_wrap;
  logic [3:0]     w_loop_inc;
  logic [3:0]     w_loop_nxt;
  logic           w_die_done_nxt;

  // Timer control depends only on registered state and inputs, never on wrap.
  always_comb begin
    w_dir_valid = (move_dir == DIR_LEFT) || (move_dir == DIR_RIGHT);
    if (dead)             w_target = S_DYING;
    else if (airborne)    w_target = S_AIR;
    else if (on_ladder)   w_target = S_CLIMB;
    else if (w_dir_valid) w_target = S_WALK;
    else                  w_target = S_IDLE;

    w_facing_nxt = r_facing;
    w_clear      = 1'b0;
    w_enable     = 1'b0;
    w_limit      = LIM_STEP;
    w_phase_last = 2'd2;
    case (r_state)
      S_DYING: begin
        w_enable     = 1'b1;
        w_limit      = LIM_DIE;
        w_phase_last = 2'd3;
      end
      S_DEAD: begin
        if (!dead) begin
          w_facing_nxt = FACE_RIGHT;
          w_clear      = 1'b1;
        end
      end
      default: begin
        if (((w_target == S_WALK) || (w_target == S_AIR)) && w_dir_valid)
          w_facing_nxt = (move_dir == DIR_RIGHT) ? FACE_RIGHT : FACE_LEFT;
        w_clear = (w_target != r_state) ||
                  ((w_target == S_WALK) && (w_facing_nxt != r_facing));
        case (w_target)
          S_WALK:  w_enable = 1'b1;
          S_CLIMB: begin
            w_enable     = climb_move;
            w_limit      = LIM_CLIMB;
            w_phase_last = 2'd1;
          end
          S_DYING: begin
            w_limit      = LIM_DIE;
            w_phase_last = 2'd3;
          end
          default: ;
        endcase
      end
    endcase
  end

  anim_frame_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear & ~pause),
    .i_enable     (w_enable & ~pause),
    .i_frame_tick (frame_tick),
    .i_limit      (w_limit),
    .i_phase_last (w_phase_last),
    .o_phase      (w_phase),
    .o_phase_nxt  (w_phase_nxt),
    .o_wrap       (w_wrap)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_loop_nxt     = r_loop_cnt;
    w_die_done_nxt = 1'b0;
    w_loop_inc     = r_loop_cnt + 4'd1;
    case (r_state)
      S_DYING: begin
        // DIE4 just finished: count the pass, then either replay or stop.
        if (w_wrap && (w_phase == 2'd3)) begin
          w_loop_nxt = w_loop_inc;
          if (w_loop_inc >= LOOPS) begin
            w_state_nxt    = S_DEAD;
            w_die_done_nxt = 1'b1;
          end
        end
      end
      S_DEAD: begin
        if (!dead) begin
          w_state_nxt = S_IDLE;
          w_loop_nxt  = 4'd0;
        end
      end
      default: begin
        w_state_nxt = w_target;
        if (w_target == S_DYING) w_loop_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_facing      <= FACE_RIGHT;
      r_loop_cnt    <= 4'd0;
      animate_state <= ANIM_STAND;
      die_done      <= 1'b0;
    end else if (!pause) begin
      r_state       <= w_state_nxt;
      r_facing      <= w_facing_nxt;
      r_loop_cnt    <= w_loop_nxt;
      animate_state <= anim_image(w_state_nxt, w_facing_nxt, w_phase_nxt);
      die_done      <= w_die_done_nxt;
    end
  end

endmodule

// File: tb/tb_mario_anim_ctrl.sv
// Directed bench for mario_anim_ctrl at default parameters; expected image
// codes are worked out by hand from the frame-rate parameters.
module tb_mario_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       pause;
  logic [1:0] move_dir;
  logic       airborne;
  logic       on_ladder;
  logic       climb_move;
  logic       dead;
  logic [3:0] animate_state;
  logic       die_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mario_anim_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .pause         (pause),
    .move_dir      (move_dir),
    .airborne      (airborne),
    .on_ladder     (on_ladder),
    .climb_move    (climb_move),
    .dead          (dead),
    .animate_state (animate_state),
    .die_done      (die_done)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each tick is a one-clk pulse followed by a quiet clk.
  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; pause = 1'b0; move_dir = 2'b00;
    airborne = 1'b0; on_ladder = 1'b0; climb_move = 1'b0; dead = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_anim", animate_state, 4'b0000);
    chk("reset_done", {3'b000, die_done}, 4'b0000);

    // Walk right: 6 ticks per image
    move_dir = 2'b10; step();
    chk("walk_r_enter", animate_state, 4'b0100);
    ticks(5);  chk("walk_r_t5", animate_state, 4'b0100);
    ticks(1);  chk("walk_r_t6", animate_state, 4'b0101);
    ticks(5);  chk("walk_r_t11", animate_state, 4'b0101);
    ticks(1);  chk("walk_r_t12", animate_state, 4'b0011);
    ticks(6);  chk("walk_r_t18", animate_state, 4'b0100);

    move_dir = 2'b11; step();
    chk("dir11_idle", animate_state, 4'b0000);

    // Reversal at tick 8 restarts the counter
    move_dir = 2'b10; step();
    ticks(8);  chk("rev_pre", animate_state, 4'b0101);
    move_dir = 2'b01; step();
    chk("rev_left1", animate_state, 4'b0001);
    ticks(5);  chk("rev_t5", animate_state, 4'b0001);
    ticks(1);  chk("rev_t6", animate_state, 4'b0010);

    // Air
    move_dir = 2'b10; step();
    chk("air_walk_r", animate_state, 4'b0100);
    airborne = 1'b1; step();
    chk("air_right", animate_state, 4'b0111);
    move_dir = 2'b01; step();
    chk("air_left", animate_state, 4'b0110);
    airborne = 1'b0; move_dir = 2'b00; step();
    chk("air_land", animate_state, 4'b0000);

    // Climb: 8 ticks per image, hold while climb_move low
    on_ladder = 1'b1; climb_move = 1'b1; step();
    chk("climb_enter", animate_state, 4'b1000);
    ticks(7);  chk("climb_t7", animate_state, 4'b1000);
    ticks(1);  chk("climb_t8", animate_state, 4'b1001);
    ticks(4);
    climb_move = 1'b0;
    ticks(20); chk("climb_hold", animate_state, 4'b1001);
    climb_move = 1'b1;
    ticks(3);  chk("climb_resume3", animate_state, 4'b1001);
    ticks(1);  chk("climb_resume4", animate_state, 4'b1000);
    on_ladder = 1'b0; step();
    chk("climb_off", animate_state, 4'b0000);
    climb_move = 1'b0;

    // Death mid-walk left, dead and airborne together
    move_dir = 2'b01; step();
    ticks(3);
    dead = 1'b1; airborne = 1'b1; step();
    chk("die_enter", animate_state, 4'b1010);
    dead = 1'b0; airborne = 1'b0;
    ticks(7);  chk("die_t7", animate_state, 4'b1010);
    ticks(1);  chk("die_t8", animate_state, 4'b1011);
    ticks(8);  chk("die_t16", animate_state, 4'b1100);
    ticks(8);  chk("die_t24", animate_state, 4'b1101);
    ticks(8);  chk("die_t32", animate_state, 4'b1010);
    chk("die_done_mid", {3'b000, die_done}, 4'b0000);
    dead = 1'b1;
    ticks(8);  chk("die_t40", animate_state, 4'b1011);
    ticks(16); chk("die_t56", animate_state, 4'b1101);
    ticks(7);  chk("die_t63", animate_state, 4'b1101);
    chk("die_done_t63", {3'b000, die_done}, 4'b0000);
    frame_tick = 1'b1; step();
    chk("dead_anim", animate_state, 4'b1101);
    chk("die_done_pulse", {3'b000, die_done}, 4'b0001);
    frame_tick = 1'b0; step();
    chk("die_done_clr", {3'b000, die_done}, 4'b0000);
    ticks(5);  chk("dead_hold", animate_state, 4'b1101);
    move_dir = 2'b00; dead = 1'b0; step();
    chk("dead_exit", animate_state, 4'b0000);
    airborne = 1'b1; step();
    chk("dead_face_r", animate_state, 4'b0111);
    airborne = 1'b0; step();

    // Pause mid-walk
    move_dir = 2'b10; step();
    ticks(4);
    pause = 1'b1;
    ticks(10); chk("pause_hold", animate_state, 4'b0100);
    move_dir = 2'b01; step();
    chk("pause_dir", animate_state, 4'b0100);
    move_dir = 2'b10; pause = 1'b0;
    ticks(1);  chk("pause_t5", animate_state, 4'b0100);
    ticks(1);  chk("pause_t6", animate_state, 4'b0101);

    // Reset during DYING
    dead = 1'b1; step();
    chk("rst_die_enter", animate_state, 4'b1010);
    dead = 1'b0;
    ticks(10); chk("rst_die_t10", animate_state, 4'b1011);
    move_dir = 2'b00; rst_n = 1'b0; step();
    chk("rst_die_anim", animate_state, 4'b0000);
    chk("rst_die_done", {3'b000, die_done}, 4'b0000);
    rst_n = 1'b1;
    ticks(8);  chk("rst_idle", animate_state, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
